hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_stats.sv | 28 ++
 rtl/hazard_controller.sv | 97 +++++++++
 tb/tb_hazard_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding and the load-use hazard test used by hazard_controller.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

    // A load writing $zero never creates a real dependency.
    function automatic logic load_use_hazard(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_stats.sv
// Saturating stall/flush event counters for the hazard controller.
// Only instantiated when HAZARD_STATS_EN is defined.
module hazard_stats
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_evt,
    input  logic              flush_evt,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_evt) stall_cycles <= sat_inc(stall_cycles);
            if (flush_evt) flush_count  <= sat_inc(flush_count);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard FSM: load-use stall, data-memory wait freeze and branch flush control.
// Optional counters (stall_cycles, flush_count) are enabled by defining HAZARD_STATS_EN.
module hazard_controller
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_ex_memRead,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       state
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
`endif
);

    hz_state_e state_q, state_d;
    logic      mem_wait;
    logic      load_use;

    assign mem_wait = dmem_req && !dmem_ready;
    assign load_use = load_use_hazard(id_ex_memRead, id_ex_rt, if_id_rs, if_id_rt);

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Branch flush only fires on a cycle where ID actually advances.
    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        pipe_write   = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_write  = 1'b0;
                        state_d     = MEM_WAIT;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = LD_STALL;
                    end else begin
                        if_id_flush = branch_taken;
                    end
                end
                LD_STALL: begin
                    if_id_flush = branch_taken;
                    state_d     = RUN;
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_write  = 1'b0;
                    end else begin
                        if_id_flush = branch_taken;
                        state_d     = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign state = rst ? RUN : state_q;

`ifdef HAZARD_STATS_EN
    hazard_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .stall_evt    (!pc_write),
        .flush_evt    (if_id_flush),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table, directed corner sequences
// and randomized stimulus against a behavioural model. Counter checks need HAZARD_STATS_EN.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       id_ex_memRead, branch_taken, dmem_req, dmem_ready;
    logic       pc_write, if_id_write, pipe_write, id_ex_bubble, if_id_flush;
    logic [1:0] state;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk           (clk),
        .rst           (rst),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .id_ex_memRead (id_ex_memRead),
        .id_ex_rt      (id_ex_rt),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .pipe_write    (pipe_write),
        .id_ex_bubble  (id_ex_bubble),
        .if_id_flush   (if_id_flush),
        .state         (state)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    typedef struct {
        logic [4:0] rs, rt, ex_rt;
        logic       mr, br, req, rdy;
        logic [4:0] exp_ctl;   // {pc_write, if_id_write, pipe_write, id_ex_bubble, if_id_flush}
        logic [1:0] exp_next;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [4:0] ctl();
        return {pc_write, if_id_write, pipe_write, id_ex_bubble, if_id_flush};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] ex, input logic br, input logic req, input logic rdy);
        if_id_rs = rs; if_id_rt = rt; id_ex_memRead = mr; id_ex_rt = ex;
        branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        #1;
    endtask

    // Behavioural model: remembers only "waiting on memory" and "bubble already inserted".
    logic m_wait, m_ld;
    logic [4:0] m_ctl;
    logic [1:0] m_state;
`ifdef HAZARD_STATS_EN
    int m_stall, m_flush;
`endif

    task automatic model_eval();
        logic mw, lu;
        mw = dmem_req && !dmem_ready;
        lu = id_ex_memRead && (id_ex_rt != 5'd0) && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
        if (rst) begin
            m_ctl = 5'b11100; m_state = 2'd0;
        end else if (m_wait) begin
            m_state = 2'd2;
            m_ctl = dmem_ready ? {4'b1110, branch_taken} : 5'b00000;
        end else if (m_ld) begin
            m_state = 2'd1;
            m_ctl = {4'b1110, branch_taken};
        end else begin
            m_state = 2'd0;
            if (mw)      m_ctl = 5'b00000;
            else if (lu) m_ctl = 5'b00110;
            else         m_ctl = {4'b1110, branch_taken};
        end
    endtask

    task automatic model_advance();
        logic mw, lu;
        mw = dmem_req && !dmem_ready;
        lu = id_ex_memRead && (id_ex_rt != 5'd0) && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
`ifdef HAZARD_STATS_EN
        if (rst) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!m_ctl[4] && m_stall < 65535) m_stall++;
            if (m_ctl[0] && m_flush < 65535) m_flush++;
        end
`endif
        if (rst) begin
            m_wait = 1'b0; m_ld = 1'b0;
        end else if (m_wait) begin
            m_wait = !dmem_ready;
        end else if (m_ld) begin
            m_ld = 1'b0;
        end else begin
            m_wait = mw;
            m_ld   = !mw && lu;
        end
    endtask

    initial begin
        vecs[0]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 2'd0};
        vecs[1]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11101, 2'd0};
        vecs[2]  = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00110, 2'd1};
        vecs[3]  = '{5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00110, 2'd1};
        vecs[4]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11100, 2'd0};
        vecs[5]  = '{5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 2'd0};
        vecs[6]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd2};
        vecs[7]  = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00000, 2'd2};
        vecs[8]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11100, 2'd0};
        vecs[9]  = '{5'd4, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00110, 2'd1};
        vecs[10] = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00110, 2'd1};

        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("reset_ctl", 32'(ctl()), 32'(5'b11100));
        check("reset_state", 32'(state), 32'd0);
        step();
        check("reset_state_after_edge", 32'(state), 32'd0);
`ifdef HAZARD_STATS_EN
        check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        check("reset_flush_count", 32'(flush_count), 32'd0);
`endif

        // Single-vector table from RUN.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            drive(vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].ex_rt,
                  vecs[i].br, vecs[i].req, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp_ctl));
            step();
            check($sformatf("vec%0d_next", i), 32'(state), 32'(vecs[i].exp_next));
        end

        // Load-use: one bubble, one LD_STALL cycle with enables high, then RUN.
        do_reset();
        drive(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_stall_ctl", 32'(ctl()), 32'(5'b00110));
        step();
        check("lu_ldstall_state", 32'(state), 32'd1);
        check("lu_ldstall_ctl", 32'(ctl()), 32'(5'b11100));
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("lu_back_run", 32'(state), 32'd0);

        // Memory wait for three cycles, then ready.
        do_reset();
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mw_frozen%0d", i), 32'(ctl()), 32'(5'b00000));
            step();
        end
        check("mw_state", 32'(state), 32'd2);
        dmem_ready = 1'b1;
        #1;
        check("mw_ready_ctl", 32'(ctl()), 32'(5'b11100));
        step();
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("mw_back_run", 32'(state), 32'd0);
`ifdef HAZARD_STATS_EN
        check("mw_stall_cycles", 32'(stall_cycles), 32'd3);
`endif

        // Branch together with load-use: suppressed, then flushed in LD_STALL.
        do_reset();
        drive(5'd5, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        check("sim_first_ctl", 32'(ctl()), 32'(5'b00110));
        step();
        check("sim_second_ctl", 32'(ctl()), 32'(5'b11101));
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
`ifdef HAZARD_STATS_EN
        check("sim_flush_count", 32'(flush_count), 32'd1);
`endif

        // Reset asserted in the second MEM_WAIT cycle.
        do_reset();
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        check("rstmw_in_wait", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        check("rstmw_ctl", 32'(ctl()), 32'(5'b11100));
        step();
        rst = 1'b0;
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rstmw_state", 32'(state), 32'd0);
        check("rstmw_ctl_after", 32'(ctl()), 32'(5'b11100));
`ifdef HAZARD_STATS_EN
        check("rstmw_stall_cleared", 32'(stall_cycles), 32'd0);

        do_reset();
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) step();
        check("sat_stall_cycles", 32'(stall_cycles), 32'h0000FFFF);
`endif

        // Randomized run against the model.
        do_reset();
        m_wait = 1'b0; m_ld = 1'b0;
`ifdef HAZARD_STATS_EN
        m_stall = 0; m_flush = 0;
`endif
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            #1;
            model_eval();
            check("rand_ctl", 32'(ctl()), 32'(m_ctl));
            check("rand_state", 32'(state), 32'(m_state));
`ifdef HAZARD_STATS_EN
            check("rand_stall_cycles", 32'(stall_cycles), 32'(m_stall));
            check("rand_flush_count", 32'(flush_count), 32'(m_flush));
`endif
            @(posedge clk);
            model_advance();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
